// File: rtl/fetch_stage_pkg.sv
// Shared types and default sizing for the fetch stage and its tag store.
// Struct widths follow the FS_* defaults; the top-level parameters must match them.
package fetch_stage_pkg;

  localparam int FS_NUM_WARPS    = 4;
  localparam int FS_NUM_THREADS  = 4;
  localparam int FS_PC_BITS      = 30;
  localparam int FS_UUID_WIDTH   = 1;
  localparam int FS_INSTR_WIDTH  = 32;
  localparam int FS_MAX_INFLIGHT = 4;

  function automatic int nw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NW_WIDTH = nw_width(FS_NUM_WARPS);

  typedef struct packed {
    logic [FS_NUM_THREADS-1:0] tmask;
    logic [FS_PC_BITS-1:0]     pc;
    logic [FS_UUID_WIDTH-1:0]  uuid;
  } fetch_entry_t;

  typedef struct packed {
    logic [FS_PC_BITS-1:0] addr;
    logic [NW_WIDTH-1:0]   tag;
  } fetch_req_t;

  typedef struct packed {
    logic [FS_INSTR_WIDTH-1:0] data;
    logic [NW_WIDTH-1:0]       tag;
  } fetch_rsp_t;

  // live: the response matched a pending warp, so retiring it returns a credit
  typedef struct packed {
    logic [NW_WIDTH-1:0]       wid;
    fetch_entry_t              entry;
    logic [FS_INSTR_WIDTH-1:0] instr;
    logic                      live;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_tag_store.sv
// Per-warp metadata parked while its icache request is outstanding.
// One synchronous write, one asynchronous read, contents not reset.
module fetch_tag_store
  import fetch_stage_pkg::*;
#(
  parameter int  NUM_WARPS = FS_NUM_WARPS,
  localparam int WID_W     = nw_width(NUM_WARPS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [WID_W-1:0] wr_addr,
  input  fetch_entry_t     wr_data,
  input  logic [WID_W-1:0] rd_addr,
  output fetch_entry_t     rd_data
);

  fetch_entry_t mem [NUM_WARPS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: schedule -> icache request, response + parked metadata -> decode packet.
// One fetch per warp in flight, global credit limit, out-of-order responses.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int  NUM_WARPS    = FS_NUM_WARPS,
  parameter int  NUM_THREADS  = FS_NUM_THREADS,
  parameter int  PC_BITS      = FS_PC_BITS,
  parameter int  UUID_WIDTH   = FS_UUID_WIDTH,
  parameter int  INSTR_WIDTH  = FS_INSTR_WIDTH,
  parameter int  MAX_INFLIGHT = FS_MAX_INFLIGHT,
  localparam int WID_W        = nw_width(NUM_WARPS),
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [WID_W-1:0]       sched_wid,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [PC_BITS-1:0]     sched_pc,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,

  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [PC_BITS-1:0]     icache_req_addr,
  output logic [WID_W-1:0]       icache_req_tag,

  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [INSTR_WIDTH-1:0] icache_rsp_data,
  input  logic [WID_W-1:0]       icache_rsp_tag,

  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [WID_W-1:0]       fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [PC_BITS-1:0]     fetch_pc,
  output logic [INSTR_WIDTH-1:0] fetch_instr,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,

  output logic [NUM_WARPS-1:0]   pending_warps,
  output logic                   err_rsp,
  output logic                   busy
);

  logic [CW-1:0]        credits, credits_nxt;
  logic [NUM_WARPS-1:0] pending_q, pending_nxt;
  logic                 req_vld, out_vld, err_q, busy_q;
  fetch_req_t           req_q;
  fetch_rsp_t           rsp;
  fetch_pkt_t           out_q;
  fetch_entry_t         wr_entry, rd_entry;
  logic                 sched_fire, rsp_fire, fetch_fire;

  assign sched_ready = (!req_vld || icache_req_ready) && (credits != '0) &&
                       !pending_q[sched_wid];
  assign icache_rsp_ready = !out_vld || fetch_ready;

  assign sched_fire = sched_valid && sched_ready;
  assign rsp_fire   = icache_rsp_valid && icache_rsp_ready;
  assign fetch_fire = out_vld && fetch_ready;

  assign wr_entry = '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};
  assign rsp      = '{data: icache_rsp_data, tag: icache_rsp_tag};

  fetch_tag_store #(.NUM_WARPS(NUM_WARPS)) u_tag_store (
    .clk     (clk),
    .wr_en   (sched_fire),
    .wr_addr (sched_wid),
    .wr_data (wr_entry),
    .rd_addr (rsp.tag),
    .rd_data (rd_entry)
  );

  // Stale responses (e.g. from before a reset) must neither clear a pending bit
  // nor return a credit they never took.
  always_comb begin
    pending_nxt = pending_q;
    if (fetch_fire && out_q.live) pending_nxt[out_q.wid] = 1'b0;
    if (sched_fire)               pending_nxt[sched_wid] = 1'b1;
  end

  always_comb begin
    credits_nxt = credits;
    unique case ({sched_fire, fetch_fire && out_q.live})
      2'b10:   credits_nxt = credits - CW'(1);
      2'b01:   credits_nxt = credits + CW'(1);
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_vld   <= 1'b0;
      out_vld   <= 1'b0;
      pending_q <= '0;
      credits   <= CW'(MAX_INFLIGHT);
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (sched_fire)            req_vld <= 1'b1;
      else if (icache_req_ready) req_vld <= 1'b0;
      if (rsp_fire)              out_vld <= 1'b1;
      else if (fetch_ready)      out_vld <= 1'b0;
      if (rsp_fire && !pending_q[rsp.tag]) err_q <= 1'b1;
      pending_q <= pending_nxt;
      credits   <= credits_nxt;
      busy_q    <= (pending_q != '0) || req_vld || out_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (sched_fire) req_q <= '{addr: sched_pc, tag: sched_wid};
    if (rsp_fire)
      out_q <= '{wid: rsp.tag, entry: rd_entry, instr: rsp.data, live: pending_q[rsp.tag]};
  end

  assign icache_req_valid = req_vld;
  assign icache_req_addr  = req_q.addr;
  assign icache_req_tag   = req_q.tag;

  assign fetch_valid = out_vld;
  assign fetch_wid   = out_q.wid;
  assign fetch_tmask = out_q.entry.tmask;
  assign fetch_pc    = out_q.entry.pc;
  assign fetch_uuid  = out_q.entry.uuid;
  assign fetch_instr = out_q.instr;

  assign pending_warps = pending_q;
  assign err_rsp       = err_q;
  assign busy          = busy_q;

  a_credit_max : assert property (@(posedge clk) disable iff (reset)
    credits <= CW'(MAX_INFLIGHT));
  a_credit_underflow : assert property (@(posedge clk) disable iff (reset)
    !(sched_fire && !(fetch_fire && out_q.live) && credits == '0));
  a_credit_overflow : assert property (@(posedge clk) disable iff (reset)
    !(fetch_fire && out_q.live && !sched_fire && credits == CW'(MAX_INFLIGHT)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instance 0 (MAX_INFLIGHT=4) is scoreboarded,
// instance 1 (MAX_INFLIGHT=2) covers credit exhaustion.
module tb_fetch_stage;

  localparam int ND = 2;

  typedef struct packed {
    logic [3:0]  tmask;
    logic [29:0] pc;
    logic [0:0]  uuid;
  } ent_t;

  typedef struct packed {
    logic [1:0]  wid;
    logic [3:0]  tmask;
    logic [29:0] pc;
    logic [0:0]  uuid;
    logic [31:0] instr;
  } pkt_t;

  logic clk = 1'b0;
  logic reset;

  logic [ND-1:0]       sched_valid, sched_ready, icache_req_valid, icache_req_ready;
  logic [ND-1:0]       icache_rsp_valid, icache_rsp_ready, fetch_valid, fetch_ready;
  logic [ND-1:0]       err_rsp, busy;
  logic [ND-1:0][1:0]  sched_wid, icache_req_tag, icache_rsp_tag, fetch_wid;
  logic [ND-1:0][3:0]  sched_tmask, fetch_tmask, pending_warps;
  logic [ND-1:0][29:0] sched_pc, icache_req_addr, fetch_pc;
  logic [ND-1:0][0:0]  sched_uuid, fetch_uuid;
  logic [ND-1:0][31:0] icache_rsp_data, fetch_instr;

  int   checks = 0;
  int   errors = 0;
  ent_t model [4];
  pkt_t exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fetch_stage #(.MAX_INFLIGHT(g == 0 ? 4 : 2)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .sched_valid      (sched_valid[g]),
      .sched_ready      (sched_ready[g]),
      .sched_wid        (sched_wid[g]),
      .sched_tmask      (sched_tmask[g]),
      .sched_pc         (sched_pc[g]),
      .sched_uuid       (sched_uuid[g]),
      .icache_req_valid (icache_req_valid[g]),
      .icache_req_ready (icache_req_ready[g]),
      .icache_req_addr  (icache_req_addr[g]),
      .icache_req_tag   (icache_req_tag[g]),
      .icache_rsp_valid (icache_rsp_valid[g]),
      .icache_rsp_ready (icache_rsp_ready[g]),
      .icache_rsp_data  (icache_rsp_data[g]),
      .icache_rsp_tag   (icache_rsp_tag[g]),
      .fetch_valid      (fetch_valid[g]),
      .fetch_ready      (fetch_ready[g]),
      .fetch_wid        (fetch_wid[g]),
      .fetch_tmask      (fetch_tmask[g]),
      .fetch_pc         (fetch_pc[g]),
      .fetch_instr      (fetch_instr[g]),
      .fetch_uuid       (fetch_uuid[g]),
      .pending_warps    (pending_warps[g]),
      .err_rsp          (err_rsp[g]),
      .busy             (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched(input int d, input logic [1:0] wid, input logic [29:0] pc,
                       input logic [3:0] tm, input logic u);
    int n = 0;
    sched_valid[d] = 1'b1;
    sched_wid[d]   = wid;
    sched_pc[d]    = pc;
    sched_tmask[d] = tm;
    sched_uuid[d]  = u;
    #1;
    while (!sched_ready[d] && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("sched_timeout", 128'(n < 20), 128'(1));
    if (d == 0) model[wid] = {tm, pc, u};
    tick();
    sched_valid[d] = 1'b0;
  endtask

  task automatic rsp(input int d, input logic [1:0] tag, input logic [31:0] data);
    int n = 0;
    icache_rsp_valid[d] = 1'b1;
    icache_rsp_tag[d]   = tag;
    icache_rsp_data[d]  = data;
    #1;
    while (!icache_rsp_ready[d] && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rsp_timeout", 128'(n < 20), 128'(1));
    if (d == 0) exp_q.push_back({tag, model[tag], data});
    tick();
    icache_rsp_valid[d] = 1'b0;
  endtask

  // Scoreboard: every retired packet on instance 0 must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && fetch_valid[0] && fetch_ready[0]) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pkt_unexpected observed_wid=%0d expected=none", fetch_wid[0]);
      end
      if (exp_q.size() != 0)
        chk("pkt", {fetch_wid[0], fetch_tmask[0], fetch_pc[0], fetch_uuid[0], fetch_instr[0]},
            exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    sched_valid      = '0;
    sched_wid        = '0;
    sched_tmask      = '0;
    sched_pc         = '0;
    sched_uuid       = '0;
    icache_req_ready = '1;
    icache_rsp_valid = '0;
    icache_rsp_data  = '0;
    icache_rsp_tag   = '0;
    fetch_ready      = '1;

    // Reset state
    #2;
    chk("rst_req_valid", icache_req_valid[0], 0);
    chk("rst_fetch_valid", fetch_valid[0], 0);
    chk("rst_pending", pending_warps[0], 0);
    chk("rst_err", err_rsp[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_credits", g_dut[0].u_dut.credits, 4);
    #20 reset = 1'b0;
    tick();

    // Single fetch
    sched(0, 2'd1, 30'h2000_0000, 4'b0011, 1'b1);
    chk("t1_req_valid", icache_req_valid[0], 1);
    chk("t1_req_addr", icache_req_addr[0], 30'h2000_0000);
    chk("t1_req_tag", icache_req_tag[0], 1);
    chk("t1_pending", pending_warps[0], 4'b0010);
    tick();
    chk("t1_busy", busy[0], 1);
    chk("t1_req_done", icache_req_valid[0], 0);
    tick();
    rsp(0, 2'd1, 32'h0000_0513);
    chk("t1_fetch_valid", fetch_valid[0], 1);
    chk("t1_fetch_wid", fetch_wid[0], 1);
    chk("t1_fetch_pc", fetch_pc[0], 30'h2000_0000);
    chk("t1_fetch_tmask", fetch_tmask[0], 4'b0011);
    chk("t1_fetch_instr", fetch_instr[0], 32'h0000_0513);
    chk("t1_pending_held", pending_warps[0], 4'b0010);
    tick();
    chk("t1_pending_clr", pending_warps[0], 4'b0000);
    chk("t1_fetch_done", fetch_valid[0], 0);
    tick();
    chk("t1_idle", busy[0], 0);

    // Request backpressure
    icache_req_ready[0] = 1'b0;
    sched(0, 2'd2, 30'h0000_3000, 4'b1111, 1'b0);
    chk("t2_req_valid", icache_req_valid[0], 1);
    sched_valid[0] = 1'b1;
    sched_wid[0]   = 2'd3;
    sched_pc[0]    = 30'h0000_3100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_sched_blocked", sched_ready[0], 0);
      chk("t2_addr_stable", icache_req_addr[0], 30'h0000_3000);
      chk("t2_tag_stable", icache_req_tag[0], 2);
      chk("t2_valid_held", icache_req_valid[0], 1);
      tick();
    end
    sched_valid[0]      = 1'b0;
    icache_req_ready[0] = 1'b1;
    tick();
    chk("t2_req_accepted", icache_req_valid[0], 0);
    tick();
    chk("t2_no_extra_req", icache_req_valid[0], 0);
    rsp(0, 2'd2, 32'h0000_0093);
    tick();

    // Out-of-order return
    sched(0, 2'd0, 30'h100, 4'b0001, 1'b0);
    sched(0, 2'd1, 30'h200, 4'b0010, 1'b1);
    sched(0, 2'd2, 30'h300, 4'b0100, 1'b0);
    chk("t3_pending", pending_warps[0], 4'b0111);
    chk("t3_credits_out", g_dut[0].u_dut.credits, 1);
    rsp(0, 2'd2, 32'hAAAA_0002);
    rsp(0, 2'd0, 32'hAAAA_0000);
    rsp(0, 2'd1, 32'hAAAA_0001);
    tick();
    tick();
    chk("t3_pending_clr", pending_warps[0], 4'b0000);
    chk("t3_credits", g_dut[0].u_dut.credits, 4);

    // Duplicate wid
    sched(0, 2'd3, 30'h400, 4'b1000, 1'b1);
    sched_valid[0] = 1'b1;
    sched_wid[0]   = 2'd3;
    sched_pc[0]    = 30'h480;
    sched_tmask[0] = 4'b1001;
    sched_uuid[0]  = 1'b0;
    #1;
    chk("t4_dup_blocked0", sched_ready[0], 0);
    tick();
    chk("t4_dup_blocked1", sched_ready[0], 0);
    rsp(0, 2'd3, 32'h0000_0333);
    #1;
    chk("t4_dup_blocked2", sched_ready[0], 0);
    @(posedge clk);
    #2;
    chk("t4_dup_released", sched_ready[0], 1);
    model[3] = {4'b1001, 30'h480, 1'b0};
    tick();
    sched_valid[0] = 1'b0;
    chk("t4_pending", pending_warps[0], 4'b1000);
    chk("t4_req_addr", icache_req_addr[0], 30'h480);
    rsp(0, 2'd3, 32'h0000_0444);
    tick();
    tick();

    // Credit exhaustion on the MAX_INFLIGHT=2 instance
    sched(1, 2'd0, 30'h500, 4'b0001, 1'b0);
    sched(1, 2'd1, 30'h600, 4'b0010, 1'b0);
    fetch_ready[1] = 1'b0;
    sched_valid[1] = 1'b1;
    sched_wid[1]   = 2'd2;
    sched_pc[1]    = 30'h700;
    #1;
    chk("t5_no_credit", sched_ready[1], 0);
    rsp(1, 2'd0, 32'hE000_0000);
    chk("t5_fetch_valid", fetch_valid[1], 1);
    chk("t5_fetch_wid0", fetch_wid[1], 0);
    chk("t5_fetch_instr0", fetch_instr[1], 32'hE000_0000);
    icache_rsp_valid[1] = 1'b1;
    icache_rsp_tag[1]   = 2'd1;
    icache_rsp_data[1]  = 32'hE000_0001;
    #1;
    chk("t5_rsp_blocked", icache_rsp_ready[1], 0);
    chk("t5_sched_blocked", sched_ready[1], 0);
    tick();
    chk("t5_out_held", fetch_wid[1], 0);
    fetch_ready[1] = 1'b1;
    #1;
    chk("t5_rsp_open", icache_rsp_ready[1], 1);
    chk("t5_still_no_credit", sched_ready[1], 0);
    tick();
    icache_rsp_valid[1] = 1'b0;
    chk("t5_credit_back", sched_ready[1], 1);
    chk("t5_fetch_wid1", fetch_wid[1], 1);
    chk("t5_fetch_instr1", fetch_instr[1], 32'hE000_0001);
    tick();
    sched_valid[1] = 1'b0;
    chk("t5_pending", pending_warps[1], 4'b0100);
    chk("t5_req_addr", icache_req_addr[1], 30'h700);

    // Reset mid-flight
    sched(0, 2'd0, 30'h800, 4'b0101, 1'b1);
    sched(0, 2'd1, 30'h900, 4'b0110, 1'b0);
    chk("t6_pending", pending_warps[0], 4'b0011);
    #2 reset = 1'b1;
    #1;
    chk("t6_req_valid", icache_req_valid[0], 0);
    chk("t6_fetch_valid", fetch_valid[0], 0);
    chk("t6_pending_rst", pending_warps[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_credits", g_dut[0].u_dut.credits, 4);
    exp_q.delete();
    #3 reset = 1'b0;
    tick();
    chk("t6_err_clear", err_rsp[0], 0);
    rsp(0, 2'd0, 32'hDEAD_0001);
    chk("t6_err_set", err_rsp[0], 1);
    chk("t6_stale_pkt", fetch_valid[0], 1);
    tick();
    tick();
    chk("t6_err_sticky", err_rsp[0], 1);
    chk("t6_pending_after", pending_warps[0], 0);
    chk("t6_credits_after", g_dut[0].u_dut.credits, 4);

    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
